// File: rtl/up3_ctrl.sv
`default_nettype none
// ============================================================================
// up3_ctrl : Moore sequencer for the up3 8-bit accumulator datapath.
// Revision : 1.0
// ============================================================================
module up3_ctrl #(
    parameter logic [7:0] OP_NOP  = 8'h00,
    parameter logic [7:0] OP_LDI  = 8'h10,
    parameter logic [7:0] OP_LDA  = 8'h01,
    parameter logic [7:0] OP_ADD  = 8'h02,
    parameter logic [7:0] OP_SUB  = 8'h03,
    parameter logic [7:0] OP_AND  = 8'h04,
    parameter logic [7:0] OP_STA  = 8'h08,
    parameter logic [7:0] OP_JMP  = 8'h20,
    parameter logic [7:0] OP_JZ   = 8'h21,
    parameter logic [7:0] OP_JN   = 8'h22,
    parameter logic [7:0] OP_HALT = 8'hFF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       run,
    input  logic [7:0] opcode,
    input  logic       zflg,
    input  logic       nflg,
    output logic       fetch,
    output logic       load_ac,
    output logic       load_pc,
    output logic       inc_pc,
    output logic       load_iru,
    output logic       load_irl,
    output logic       store_mem,
    output logic       halted,
    output logic       illegal,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_F0   = 4'd0,
        S_F1   = 4'd1,
        S_F2   = 4'd2,
        S_F3   = 4'd3,
        S_DEC  = 4'd4,
        S_EXI  = 4'd5,
        S_M0   = 4'd6,
        S_M1   = 4'd7,
        S_ST   = 4'd8,
        S_JMP  = 4'd9,
        S_HALT = 4'd10,
        S_ILL  = 4'd11
    } state_t;

    state_t state_q;
    state_t state_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_F0;
        end else begin
            state_q <= state_d;
        end
    end

    // Outputs depend on state_q only; inputs steer the next state alone.
    always_comb begin
        state_d   = S_F0;
        fetch     = 1'b0;
        load_ac   = 1'b0;
        load_pc   = 1'b0;
        inc_pc    = 1'b0;
        load_iru  = 1'b0;
        load_irl  = 1'b0;
        store_mem = 1'b0;
        halted    = 1'b0;
        illegal   = 1'b0;
        case (state_q)
            S_F0: begin
                fetch   = 1'b1;
                state_d = run ? S_F1 : S_F0;
            end
            S_F1: begin
                fetch    = 1'b1;
                load_iru = 1'b1;
                inc_pc   = 1'b1;
                state_d  = S_F2;
            end
            S_F2: begin
                // RAM captures the incremented PC for the operand byte
                fetch   = 1'b1;
                state_d = S_F3;
            end
            S_F3: begin
                fetch    = 1'b1;
                load_irl = 1'b1;
                inc_pc   = 1'b1;
                state_d  = S_DEC;
            end
            S_DEC: begin
                case (opcode)
                    OP_NOP:  state_d = S_F0;
                    OP_LDI:  state_d = S_EXI;
                    OP_LDA,
                    OP_ADD,
                    OP_SUB,
                    OP_AND:  state_d = S_M0;
                    OP_STA:  state_d = S_ST;
                    OP_JMP:  state_d = S_JMP;
                    OP_JZ:   state_d = zflg ? S_JMP : S_F0;
                    OP_JN:   state_d = nflg ? S_JMP : S_F0;
                    OP_HALT: state_d = S_HALT;
                    default: state_d = S_ILL;
                endcase
            end
            S_EXI: begin
                load_ac = 1'b1;
                state_d = S_F0;
            end
            S_M0: begin
                state_d = S_M1;
            end
            S_M1: begin
                load_ac = 1'b1;
                state_d = S_F0;
            end
            S_ST: begin
                store_mem = 1'b1;
                state_d   = S_F0;
            end
            S_JMP: begin
                load_pc = 1'b1;
                state_d = S_F0;
            end
            S_HALT: begin
                halted  = 1'b1;
                state_d = S_HALT;
            end
            S_ILL: begin
                illegal = 1'b1;
                state_d = S_F0;
            end
            default: begin
                // Unused encodings recover to the fetch state
                fetch   = 1'b1;
                state_d = S_F0;
            end
        endcase
    end

    assign state = state_q;

endmodule
`default_nettype wire

// File: tb/tb_up3_ctrl.sv
`default_nettype none
// tb_up3_ctrl : up3_ctrl inside a small datapath, scored against an ISA-level model.
module tb_up3_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       run = 1'b0;
    logic [7:0] opcode;
    logic       zflg, nflg;
    logic       fetch, load_ac, load_pc, inc_pc, load_iru, load_irl, store_mem, halted, illegal;
    logic [3:0] state;

    up3_ctrl dut (
        .clk(clk), .reset(reset), .run(run), .opcode(opcode), .zflg(zflg), .nflg(nflg),
        .fetch(fetch), .load_ac(load_ac), .load_pc(load_pc), .inc_pc(inc_pc),
        .load_iru(load_iru), .load_irl(load_irl), .store_mem(store_mem),
        .halted(halted), .illegal(illegal), .state(state)
    );

    always #5 clk = ~clk;

    // Datapath with synchronous RAM (address registered, q valid next cycle)
    logic [7:0] ram [256];
    logic [7:0] pc, ac, ir_u, ir_l, addr_q, q, alu;
    logic       ld_en = 1'b0;
    logic [7:0] ld_addr = 8'h00, ld_data = 8'h00;

    assign q      = ram[addr_q];
    assign opcode = ir_u;
    assign zflg   = (ac == 8'h00);
    assign nflg   = ac[7];

    always_comb begin
        case (ir_u)
            8'h10:   alu = ir_l;
            8'h02:   alu = ac + q;
            8'h03:   alu = ac - q;
            8'h04:   alu = ac & q;
            default: alu = q;
        endcase
    end

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc <= 8'h00; ac <= 8'h00; ir_u <= 8'h00; ir_l <= 8'h00; addr_q <= 8'h00;
        end else begin
            addr_q <= fetch ? pc : ir_l;
            if (load_iru) ir_u <= q;
            if (load_irl) ir_l <= q;
            if (inc_pc) pc <= pc + 8'd1;
            else if (load_pc) pc <= ir_l;
            if (load_ac) ac <= alu;
        end
    end

    always @(posedge clk) begin
        if (ld_en) ram[ld_addr] <= ld_data;
        else if (store_mem) ram[ir_l] <= ac;
    end

    // Scoreboard
    typedef struct {
        logic [7:0] pc;
        logic [7:0] ac;
        int         lat;
        int         ill;
        int         st;
        logic [7:0] sa;
        logic [7:0] sd;
        bit         halt;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] mm [256];
    int         tests = 0, fails = 0;
    int         started = 0, k_lim = 0;
    bit         last_halt = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, req, $time);
        end
    endtask

    // Instruction-level reference: each instruction is one step of plain arithmetic
    task automatic model_run(input int k);
        logic [7:0] mpc, mac, op, opd, pc1;
        exp_t e;
        mpc = 8'h00; mac = 8'h00; last_halt = 0;
        for (int i = 0; i < k; i++) begin
            pc1 = mpc + 8'd1;
            op  = mm[mpc];
            opd = mm[pc1];
            mpc = mpc + 8'd2;
            e.ill = 0; e.st = 0; e.sa = 8'h00; e.sd = 8'h00; e.halt = 0; e.lat = 5;
            case (op)
                8'h00: e.lat = 5;
                8'h10: begin mac = opd; e.lat = 6; end
                8'h01: begin mac = mm[opd]; e.lat = 7; end
                8'h02: begin mac = mac + mm[opd]; e.lat = 7; end
                8'h03: begin mac = mac - mm[opd]; e.lat = 7; end
                8'h04: begin mac = mac & mm[opd]; e.lat = 7; end
                8'h08: begin mm[opd] = mac; e.st = 1; e.sa = opd; e.sd = mac; e.lat = 6; end
                8'h20: begin mpc = opd; e.lat = 6; end
                8'h21: if (mac == 8'h00) begin mpc = opd; e.lat = 6; end else e.lat = 5;
                8'h22: if (mac[7]) begin mpc = opd; e.lat = 6; end else e.lat = 5;
                8'hFF: begin e.halt = 1; e.lat = 5; end
                default: begin e.ill = 1; e.lat = 6; end
            endcase
            e.pc = mpc; e.ac = mac;
            exp_q.push_back(e);
            if (e.halt) begin
                last_halt = 1;
                break;
            end
        end
    endtask

    // Monitor: tracks each instruction from its S_F0 launch to completion
    bit         in_instr = 0;
    int         cyc = 0, st_cnt = 0, ill_cnt = 0;
    logic [7:0] st_a = 8'h00, st_d = 8'h00;

    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            in_instr = 0;
        end else begin
            chk("inv_pc_inc", {31'd0, load_pc & inc_pc}, 0);
            chk("inv_store_fetch", {31'd0, store_mem & fetch}, 0);
            chk("inv_onehot", {31'd0, ($countones({load_iru, load_irl, load_ac, store_mem, load_pc}) > 1)}, 0);
            chk("inv_halted", {31'd0, halted}, {31'd0, state == 4'd10});
            if (in_instr) begin
                if (store_mem) begin st_cnt++; st_a = ir_l; st_d = ac; end
                if (illegal) ill_cnt++;
                if (state == 4'd0 || state == 4'd10) begin
                    in_instr = 0;
                    if (exp_q.size() == 0) begin
                        chk("unexpected_instr", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("latency", cyc, e.lat);
                        chk("pc", {24'd0, pc}, {24'd0, e.pc});
                        chk("ac", {24'd0, ac}, {24'd0, e.ac});
                        chk("store_count", st_cnt, e.st);
                        if (e.st != 0) begin
                            chk("store_addr", {24'd0, st_a}, {24'd0, e.sa});
                            chk("store_data", {24'd0, st_d}, {24'd0, e.sd});
                        end
                        chk("illegal_pulses", ill_cnt, e.ill);
                        chk("halt_state", {31'd0, state == 4'd10}, {31'd0, e.halt});
                    end
                end else begin
                    cyc++;
                end
            end
            if (state == 4'd0 && run) begin
                in_instr = 1; cyc = 1; st_cnt = 0; ill_cnt = 0;
                started++;
            end
        end
    end

    task automatic load_ram();
        ld_en = 1'b1;
        for (int i = 0; i < 256; i++) begin
            ld_addr = i[7:0];
            ld_data = mm[i];
            @(posedge clk); #1;
        end
        ld_en = 1'b0;
    endtask

    task automatic clear_mm();
        for (int i = 0; i < 256; i++) mm[i] = 8'h00;
    endtask

    function automatic logic [7:0] rnd_byte();
        logic [7:0] b;
        case ($urandom_range(0, 19))
            0, 1, 2: b = 8'($urandom);
            3:       b = 8'h00;
            4, 5:    b = 8'h10;
            6:       b = 8'h01;
            7, 8:    b = 8'h02;
            9, 10:   b = 8'h03;
            11:      b = 8'h04;
            12, 13:  b = 8'h08;
            14:      b = 8'h20;
            15, 16:  b = 8'h21;
            17, 18:  b = 8'h22;
            default: b = 8'hFF;
        endcase
        return b;
    endfunction

    task automatic run_prog(input int k);
        int n;
        reset = 1'b0; run = 1'b0;
        exp_q.delete();
        load_ram();
        model_run(k);
        k_lim = k; started = 0;
        @(posedge clk); #1 reset = 1'b1;
        n = 0;
        while (exp_q.size() != 0 && n < 4000) begin
            @(posedge clk); #1;
            run = (started < k_lim) && ($urandom_range(0, 3) != 0);
            n++;
        end
        run = 1'b0;
        chk("prog_timeout", exp_q.size(), 0);
        if (last_halt) begin
            repeat (3) @(posedge clk);
            #1;
            chk("halt_hold_state", {28'd0, state}, 32'd10);
            chk("halt_hold_flag", {31'd0, halted}, 1);
        end
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset = 1'b0;
        #1;
        chk("reset_state", {28'd0, state}, 0);
        chk("reset_fetch", {31'd0, fetch}, 1);
        chk("reset_ctrl", {24'd0, load_ac, load_pc, inc_pc, load_iru, load_irl, store_mem, halted, illegal}, 0);

        // LDI 5; STA 40h; HALT
        clear_mm();
        mm[0] = 8'h10; mm[1] = 8'h05; mm[2] = 8'h08; mm[3] = 8'h40; mm[4] = 8'hFF;
        run_prog(3);

        // LDI 0; JZ 10h (taken) then LDI 1; JZ 50h (untaken); HALT
        clear_mm();
        mm[0] = 8'h10; mm[1] = 8'h00; mm[2] = 8'h21; mm[3] = 8'h10;
        mm[8'h10] = 8'h10; mm[8'h11] = 8'h01; mm[8'h12] = 8'h21; mm[8'h13] = 8'h50; mm[8'h14] = 8'hFF;
        run_prog(5);

        // LDI 80h; JN 20h (taken); LDI 7; SUB 30h; HALT
        clear_mm();
        mm[0] = 8'h10; mm[1] = 8'h80; mm[2] = 8'h22; mm[3] = 8'h20;
        mm[8'h20] = 8'h10; mm[8'h21] = 8'h07; mm[8'h22] = 8'h03; mm[8'h23] = 8'h30; mm[8'h24] = 8'hFF;
        mm[8'h30] = 8'h03;
        run_prog(5);

        // Illegal opcode, then execution continues
        clear_mm();
        mm[0] = 8'h77; mm[1] = 8'h12; mm[2] = 8'h10; mm[3] = 8'h09; mm[4] = 8'hFF;
        run_prog(3);

        // run=0 holds S_F0 without advancing PC
        reset = 1'b0;
        clear_mm();
        exp_q.delete();
        load_ram();
        model_run(1);
        @(posedge clk); #1 reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("stall_state", {28'd0, state}, 0);
            chk("stall_inc_pc", {31'd0, inc_pc}, 0);
        end
        @(posedge clk); #1 run = 1'b1;
        @(posedge clk); #1 run = 1'b0;
        chk("resume_state", {28'd0, state}, 1);
        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(posedge clk); #1; n++;
        end
        chk("stall_prog_timeout", exp_q.size(), 0);

        // Asynchronous reset in the middle of a memory operation
        reset = 1'b0;
        clear_mm();
        mm[0] = 8'h01; mm[1] = 8'h30;
        exp_q.delete();
        load_ram();
        model_run(1);
        @(posedge clk); #1 reset = 1'b1; run = 1'b1;
        n = 0;
        while (state != 4'd6 && n < 50) begin
            @(posedge clk); #1; n++;
        end
        chk("reach_m0", {28'd0, state}, 6);
        #2 reset = 1'b0;
        #1;
        chk("async_rst_state", {28'd0, state}, 0);
        chk("async_rst_fetch", {31'd0, fetch}, 1);
        chk("async_rst_ctrl", {24'd0, load_ac, load_pc, inc_pc, load_iru, load_irl, store_mem, halted, illegal}, 0);
        run = 1'b0;
        exp_q.delete();
        @(posedge clk); #1;

        // Randomised programs
        for (int p = 0; p < 8; p++) begin
            for (int i = 0; i < 256; i++) mm[i] = rnd_byte();
            run_prog(40);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
